// File: rtl/pea_core_if.sv
// ---------------------------------------------------------------------------
// pea_core_if
// Bundles the FIFO handshake and control/status signals between the
// Polynomial Evaluation Accelerator execution core and its surroundings
// (command/data FIFOs, result/status FIFOs and the PEA_enable block).
//
//   enable        : tokens/space sufficient for the current mode
//   command_in    : head of the command FIFO (valid the cycle after a pop)
//   data_in       : head of the data FIFO (valid the cycle after a pop)
//   rd_en_command : single-cycle command FIFO pop
//   rd_en_data    : single-cycle data FIFO pop
//   wr_en_result  : push result_out
//   wr_en_status  : push status_out
//   result_out    : 32-bit evaluated value
//   status_out    : 32-bit status word
//   mode, N, b    : current mode, addressed degree, batch count
//
// master = execution core, slave = FIFO/enable environment.
// ---------------------------------------------------------------------------
interface pea_core_if;
    logic        enable;
    logic [15:0] command_in;
    logic [15:0] data_in;
    logic        rd_en_command;
    logic        rd_en_data;
    logic        wr_en_result;
    logic        wr_en_status;
    logic [31:0] result_out;
    logic [31:0] status_out;
    logic [2:0]  mode;
    logic [3:0]  N;
    logic [4:0]  b;

    modport master (
        input  enable, command_in, data_in,
        output rd_en_command, rd_en_data, wr_en_result, wr_en_status,
        output result_out, status_out, mode, N, b
    );

    modport slave (
        output enable, command_in, data_in,
        input  rd_en_command, rd_en_data, wr_en_result, wr_en_status,
        input  result_out, status_out, mode, N, b
    );
endinterface

// File: rtl/pea_core.sv
// ---------------------------------------------------------------------------
// pea_core
// Execution datapath of the Polynomial Evaluation Accelerator. Pops commands
// and operands, stores up to 8 polynomials (16 x 16-bit coefficients each),
// evaluates them by Horner's rule and pushes 32-bit results/status words.
// Token width is 16 bits; results and status words are 32 bits. The
// 1024-deep FIFOs live outside this block.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   pea  : pea_core_if.master (FIFO handshakes, enable, mode/N/b)
// ---------------------------------------------------------------------------
module pea_core (
    input  logic          clk,
    input  logic          rst,
    pea_core_if.master    pea
);
    localparam logic [2:0] OP_STP   = 3'b001;
    localparam logic [2:0] OP_EVP   = 3'b010;
    localparam logic [2:0] OP_EVB   = 3'b011;
    localparam logic [2:0] OP_RST   = 3'b101;
    localparam logic [2:0] MODE_GET = 3'b000;
    localparam logic [2:0] MODE_OUT = 3'b100;

    typedef enum logic [3:0] {
        S_CMD, S_DEC, S_STP_WAIT, S_STP_POP, S_EV_WAIT, S_EV_POP,
        S_EV_LOAD, S_EV_STEP, S_EV_WR, S_RST, S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        mode_q, mode_d, op_q, op_d, slot_q, slot_d;
    logic [3:0]        n_q, n_d, idx_q, idx_d;
    logic [4:0]        b_q, b_d, bcnt_q, bcnt_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [15:0]       code_q, code_d, x_q, x_d;
    logic [31:0]       acc_q, acc_d;
    logic              res_pend_q, res_pend_d;
    logic [7:0]        valid_q, valid_d;
    logic [7:0][3:0]   deg_q, deg_d;

    // Coefficient store: address = {slot, coefficient index}
    logic [15:0]       coef_mem [0:127];
    logic [15:0]       coef_rd_q;
    logic [3:0]        rd_idx;
    logic              mem_we;

    logic              rd_cmd, rd_dat, wr_res, wr_sta, horner_done;

    logic [2:0]        cmd_op, cmd_slot;
    logic [3:0]        cmd_n;
    logic [4:0]        cmd_b;
    logic              unused_cmd_bit;

    assign cmd_op         = pea.command_in[15:13];
    assign cmd_slot       = pea.command_in[12:10];
    assign cmd_n          = pea.command_in[9:6];
    assign cmd_b          = pea.command_in[4:0];
    assign unused_cmd_bit = pea.command_in[5];

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        op_d        = op_q;
        slot_d      = slot_q;
        n_d         = n_q;
        b_d         = b_q;
        bcnt_d      = bcnt_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        idx_d       = idx_q;
        x_d         = x_q;
        acc_d       = acc_q;
        res_pend_d  = res_pend_q;
        valid_d     = valid_q;
        deg_d       = deg_q;
        rd_idx      = idx_q;
        mem_we      = 1'b0;
        rd_cmd      = 1'b0;
        rd_dat      = 1'b0;
        wr_res      = 1'b0;
        wr_sta      = 1'b0;
        horner_done = 1'b0;

        case (state_q)
            S_CMD: begin
                if (pea.enable) begin
                    rd_cmd  = 1'b1;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                op_d       = cmd_op;
                slot_d     = cmd_slot;
                b_d        = cmd_b;
                bcnt_d     = cmd_b;
                cnt_d      = 6'd0;
                code_d     = 16'd0;
                res_pend_d = 1'b0;
                n_d        = (cmd_op == OP_STP) ? cmd_n : deg_q[cmd_slot];
                // Errors are resolved here so no data is ever popped for them
                case (cmd_op)
                    OP_STP: begin
                        mode_d  = OP_STP;
                        state_d = S_STP_WAIT;
                    end
                    OP_EVP, OP_EVB: begin
                        if (!valid_q[cmd_slot]) begin
                            code_d  = 16'd1;
                            mode_d  = MODE_OUT;
                            state_d = S_OUT;
                        end else if (cmd_op == OP_EVB && cmd_b == 5'd0) begin
                            code_d  = 16'd3;
                            mode_d  = MODE_OUT;
                            state_d = S_OUT;
                        end else begin
                            mode_d  = cmd_op;
                            state_d = S_EV_WAIT;
                        end
                    end
                    OP_RST: begin
                        mode_d  = OP_RST;
                        state_d = S_RST;
                    end
                    default: begin
                        code_d  = 16'd2;
                        mode_d  = MODE_OUT;
                        state_d = S_OUT;
                    end
                endcase
            end
            S_RST: begin
                valid_d = 8'd0;
                mode_d  = MODE_OUT;
                state_d = S_OUT;
            end
            S_STP_WAIT: begin
                if (pea.enable) begin
                    rd_dat  = 1'b1;
                    idx_d   = n_q;
                    state_d = S_STP_POP;
                end
            end
            S_STP_POP: begin
                // Each cycle stores the word popped one cycle earlier,
                // highest degree first, and issues the next pop if any remain
                mem_we = 1'b1;
                if (idx_q == 4'd0) begin
                    valid_d[slot_q] = 1'b1;
                    deg_d[slot_q]   = n_q;
                    mode_d          = MODE_OUT;
                    state_d         = S_OUT;
                end else begin
                    rd_dat = 1'b1;
                    idx_d  = idx_q - 4'd1;
                end
            end
            S_EV_WAIT: begin
                rd_idx = n_q;
                if (pea.enable) begin
                    rd_dat  = 1'b1;
                    state_d = S_EV_LOAD;
                end
            end
            S_EV_POP: begin
                // Later EVB samples: enable was checked once for the batch
                rd_idx  = n_q;
                rd_dat  = 1'b1;
                state_d = S_EV_LOAD;
            end
            S_EV_LOAD: begin
                x_d   = pea.data_in;
                acc_d = {16'd0, coef_rd_q};
                if (n_q == 4'd0) begin
                    horner_done = 1'b1;
                end else begin
                    rd_idx  = n_q - 4'd1;
                    idx_d   = n_q - 4'd1;
                    state_d = S_EV_STEP;
                end
            end
            S_EV_STEP: begin
                // coef_rd_q holds c_idx, prefetched one cycle ahead
                acc_d = acc_q * {16'd0, x_q} + {16'd0, coef_rd_q};
                if (idx_q == 4'd0) begin
                    horner_done = 1'b1;
                end else begin
                    rd_idx = idx_q - 4'd1;
                    idx_d  = idx_q - 4'd1;
                end
            end
            S_EV_WR: begin
                wr_res = 1'b1;
                cnt_d  = cnt_q + 6'd1;
                bcnt_d = bcnt_q - 5'd1;
                if (bcnt_q == 5'd1) begin
                    mode_d  = MODE_OUT;
                    state_d = S_OUT;
                end else begin
                    state_d = S_EV_POP;
                end
            end
            S_OUT: begin
                if (pea.enable) begin
                    wr_sta     = 1'b1;
                    wr_res     = res_pend_q;
                    res_pend_d = 1'b0;
                    mode_d     = MODE_GET;
                    state_d    = S_CMD;
                end
            end
            default: begin
                state_d = S_CMD;
                mode_d  = MODE_GET;
            end
        endcase

        if (horner_done) begin
            if (op_q == OP_EVB) begin
                state_d = S_EV_WR;
            end else begin
                // EVP writes result and status together from OUTPUT
                res_pend_d = 1'b1;
                cnt_d      = 6'd1;
                mode_d     = MODE_OUT;
                state_d    = S_OUT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_CMD;
            mode_q     <= MODE_GET;
            op_q       <= 3'd0;
            slot_q     <= 3'd0;
            n_q        <= 4'd0;
            b_q        <= 5'd0;
            bcnt_q     <= 5'd0;
            cnt_q      <= 6'd0;
            code_q     <= 16'd0;
            idx_q      <= 4'd0;
            x_q        <= 16'd0;
            acc_q      <= 32'd0;
            res_pend_q <= 1'b0;
            valid_q    <= 8'd0;
            deg_q      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            op_q       <= op_d;
            slot_q     <= slot_d;
            n_q        <= n_d;
            b_q        <= b_d;
            bcnt_q     <= bcnt_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            acc_q      <= acc_d;
            res_pend_q <= res_pend_d;
            valid_q    <= valid_d;
            deg_q      <= deg_d;
        end
    end

    // Coefficient RAM: contents are don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        if (mem_we) begin
            coef_mem[{slot_q, idx_q}] <= pea.data_in;
        end
        coef_rd_q <= coef_mem[{slot_q, rd_idx}];
    end

    // Strobes are masked by rst so nothing fires while reset is held,
    // even though the idle state would otherwise pop on enable
    assign pea.rd_en_command = rd_cmd & ~rst;
    assign pea.rd_en_data    = rd_dat & ~rst;
    assign pea.wr_en_result  = wr_res & ~rst;
    assign pea.wr_en_status  = wr_sta & ~rst;
    assign pea.result_out    = acc_q;
    assign pea.status_out    = {op_q, slot_q, n_q, cnt_q, code_q};
    assign pea.mode          = mode_q;
    assign pea.N             = n_q;
    assign pea.b             = b_q;
endmodule

// File: doc/pea_core.md
# pea_core

Execution datapath of the Polynomial Evaluation Accelerator, directly downstream of `PEA_enable`. It pops commands and operands from the input command/data FIFOs, stores polynomial coefficients, and evaluates polynomials by Horner's rule. It pushes 32-bit results and status words into the result/status FIFOs. It publishes its current `mode`, `N` and `b` to `PEA_enable` and performs a firing only when `enable` is high.

## Interface
- `word_size`, 16, input token width; result/status width is 2*word_size.
- `buffer_size`, 1024, FIFO depth (context only; no internal buffering of that size).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset. One clock domain.
- `enable`  in  1  from `PEA_enable`: tokens/space sufficient for the current `mode`.
- `command_in`  in  16  head of command FIFO, valid the cycle after `rd_en_command`.
- `data_in`  in  16  head of data FIFO, valid the cycle after `rd_en_data`.
- `rd_en_command`  out  1  single-cycle pop of command FIFO.
- `rd_en_data`  out  1  single-cycle pop of data FIFO.
- `wr_en_result`  out  1  push `result_out`.
- `wr_en_status`  out  1  push `status_out`.
- `result_out`  out  32  evaluated value.
- `status_out`  out  32  status word.
- `mode`  out  3  GET_COMMAND=000, STP=001, EVP=010, EVB=011, OUTPUT=100, RST=101.
- `N`  out  4  degree of the addressed polynomial.
- `b`  out  5  EVB batch count.

## Operation
- Command word: [15:13] op (001 STP, 010 EVP, 011 EVB, 101 RST), [12:10] slot (8 polynomials), [9:6] degree N (STP only), [4:0] b (EVB only).
- Storage: 8 slots × 16 coefficients × 16 bits, per-slot valid flag, per-slot degree.
- GET_COMMAND: when `enable`, pulse `rd_en_command`. Next cycle latch the command, decode and set `mode`.
- STP: on `enable` (data ≥ N+1), issue N+1 back-to-back `rd_en_data` pulses. Words arrive highest-degree first: c_N … c_0. Then set valid, store N, go OUTPUT (status only, code 0).
- EVP: on `enable`, pop one x. Set acc = c_N, then N steps acc = acc·x + c_i for i = N−1 … 0. Go OUTPUT and write result and status in the same cycle.
- EVB: on `enable` (checked once; data ≥ b, result space ≥ b, status ≥ 1), evaluate b x values serially. Each x runs pop → load → N steps → `wr_en_result`. One status word follows after the last result.
- RST (command): clear all valid flags. Write status code 0.
- Errors are detected at decode. No data is popped, no result is written, and the block goes to OUTPUT to write status only:
  - code 1: EVP/EVB on an invalid slot.
  - code 2: illegal op.
  - code 3: EVB with b = 0.
- OUTPUT: waits for `enable` (status space ≥ 1, plus result space for EVP), writes, then returns to GET_COMMAND.
- Status word fields:
  - [31:29] op
  - [28:26] slot
  - [25:22] slot N
  - [21:16] count of results written by this command
  - [15:0] code
- Arithmetic: unsigned. Product is 32×16, truncated to the low 32 bits. The add wraps modulo 2^32.
- While `mode` is STP, EVP or EVB, `N` reflects the addressed slot's stored degree (STP: command N). `b` is held from the command.

## Timing
- Reset: all outputs 0, `mode` = GET_COMMAND, acc 0, all valid flags 0. Coefficient contents are don't-care.
- Reset asserted mid-operation aborts immediately. No further pops or pushes occur; partial results are discarded.
- Command decode: `mode` updates in the cycle after the `rd_en_command` pulse.
- EVP, with `rd_en_data` at cycle k:
  - k+1: x latched, acc = c_N.
  - k+2 … k+1+N: Horner steps.
  - k+2+N: `wr_en_result` = `wr_en_status` = 1 (if `enable`).
- N = 0: write at k+2.
- EVB: per-x period is N+3 cycles. The next `rd_en_data` follows each `wr_en_result` by 1 cycle.
- All write/pop strobes are exactly one cycle wide. No strobe is issued while `enable` is low in a waiting state.
- The block never pops and pushes in the same cycle, except the EVB status push, which follows the last result by 1 cycle.

## Test plan
- STP slot0 N=2, data 1,2,3; then EVP slot0 x=2 → status code 0; result 0x0000000B; status count 1.
- EVB slot0 b=3, x=0,1,5 → results 3, 6, 38 in order; one status word with count 3, code 0.
- STP slot1 N=2, data FFFF,0,0; EVP slot1 x=FFFF → result 0x0002FFFF (wrap check).
- EVP slot5 with no prior STP → status code 1; no `wr_en_result`; data FIFO occupancy unchanged. Then op 111 → code 2. EVB b=0 → code 3.
- RST command, then EVP slot0 → code 1. Hold `enable` low for 10 cycles in EVP → no strobes; release → normal completion.
- Assert `rst` during the EVB second x → all outputs 0 immediately, `mode` = 000; no further pushes after deassert until a new command.
